ram8: RTL and testbench

RAM8 -- requirements
Module: ram8

---
 rtl/ram8.sv | 43 ++++
 tb/tb_ram8.sv | 138 +++++++++++++
 2 files changed

// File: rtl/ram8.sv
// ram8: 8-word WIDTH-bit RAM (clk, reset sync high, in write data, load write enable, address 0..7, out = word[address] combinational)
module ram8_cell (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) q <= reset ? 1'b0 : load ? d : q;
endmodule

module ram8_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    ram8_cell u_cell (.clk(clk), .reset(reset), .load(load), .d(d[b]), .q(q[b]));
  end
endmodule

module ram8 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);
  logic [7:0]       sel;
  logic [WIDTH-1:0] words [8];
  assign sel = load ? 8'b1 << address : 8'b0;
  for (genvar w = 0; w < 8; w++) begin : g_word
    ram8_word #(.WIDTH(WIDTH)) u_word (.clk(clk), .reset(reset), .load(sel[w]), .d(in), .q(words[w]));
  end
  assign out = words[address];
endmodule

// File: tb/tb_ram8.sv
// tb_ram8: directed and randomized checks of ram8 against an array model
module tb_ram8;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic [2:0]  address = '0;
  logic [15:0] out;
  logic [15:0] mem [8];
  int          checks = 0;
  int          errors = 0;

  ram8 #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .in(in), .load(load), .address(address), .out(out));

  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (reset) foreach (mem[i]) mem[i] = '0;
    else if (load) mem[address] = in;
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    #1;
    checks++;
    assert (out === exp) else begin
      errors++;
      $error("FAIL %s addr=%0d got %h exp %h", tag, address, out, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      chk(tag, mem[a]);
    end
  endtask

  initial begin
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      chk("reset_sweep", 16'h0000);
    end
    for (int a = 0; a < 8; a++) begin
      wr(3'(a), 16'(16'h1111 * (a + 1)));
      sweep("fill_intact");
    end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      chk("fill_readback", 16'(16'h1111 * (a + 1)));
    end
    wr(3'd3, 16'hBEEF);
    address = 3'd3;
    in = 16'h0000;
    load = 1'b0;
    repeat (3) begin
      tick();
      chk("load_gate", 16'hBEEF);
    end
    wr(3'd5, 16'h00AA);
    address = 3'd5;
    in = 16'h0055;
    load = 1'b1;
    chk("rdw_before", 16'h00AA);
    tick();
    chk("rdw_after", 16'h0055);
    address = 3'd2;
    in = 16'hFFFF;
    load = 1'b0;
    chk("other_before", 16'h3333);
    tick();
    chk("other_after", 16'h3333);
    wr(3'd0, 16'h1234);
    address = 3'd0;
    chk("pre_reset", 16'h1234);
    reset = 1'b1;
    load = 1'b1;
    in = 16'hFFFF;
    tick();
    chk("reset_prio", 16'h0000);
    reset = 1'b0;
    in = 16'h0042;
    tick();
    load = 1'b0;
    chk("post_reset_wr", 16'h0042);
    sweep("post_reset_sweep");
    reset = 1'b1;
    load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      address = 3'($urandom_range(0, 7));
      in = 16'($urandom);
      tick();
      chk("reset_held", 16'h0000);
    end
    reset = 1'b0;
    load = 1'b0;
    for (int a = 0; a < 8; a++) wr(3'(a), 16'($urandom));
    load = 1'b1;
    for (int k = 0; k < 6; k++) begin
      address = 3'($urandom_range(0, 7));
      in = 16'($urandom);
      #2;
    end
    address = 3'd6;
    in = 16'hC0DE;
    tick();
    load = 1'b0;
    address = 3'd6;
    chk("glitch_target", 16'hC0DE);
    sweep("glitch_others");
    for (int k = 0; k < 300; k++) begin
      reset = ($urandom_range(0, 24) == 0);
      load = 1'($urandom);
      address = 3'($urandom_range(0, 7));
      in = 16'($urandom);
      chk("rand_before", mem[address]);
      tick();
      chk("rand_after", mem[address]);
    end
    reset = 1'b0;
    load = 1'b0;
    sweep("final_sweep");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
